// File: rtl/ctrl_mem_sequencer.sv
// Control-memory front end for one CGRA tile: loads config words into the
// register file, then steps the read address through the active contexts.
module ctrl_mem_sequencer #(
  parameter int unsigned NUM_CTRL = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned CFG_W    = 49,
  parameter int unsigned ITER_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CFG_W-1:0]    cfg_recv_msg,
  input  logic                cfg_recv_val,
  output logic                cfg_recv_rdy,
  input  logic                start,
  input  logic [ADDR_W:0]     num_ctx,
  input  logic [ITER_W-1:0]   iter_limit,
  output logic                rf_wen,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [CFG_W-1:0]    rf_wdata,
  output logic [ADDR_W-1:0]   rf_raddr,
  input  logic [CFG_W-1:0]    rf_rdata,
  output logic [CFG_W-1:0]    cfg_out,
  output logic                cfg_out_val,
  input  logic                cfg_out_rdy,
  output logic                busy,
  output logic                done,
  output logic [ITER_W-1:0]   iter_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0]   NUM_CTX_MAX = (ADDR_W+1)'(NUM_CTRL);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_CTRL - 1);

  state_t              state;
  logic [ADDR_W-1:0]   load_ptr;
  logic [ADDR_W-1:0]   ctx_ptr;
  logic [ADDR_W:0]     num_ctx_q;
  logic [ITER_W-1:0]   iter_limit_q;

  logic                fire;
  logic                last_ctx;
  logic [ADDR_W:0]     num_ctx_clamped;
  logic [ADDR_W:0]     last_idx;
  logic [ITER_W-1:0]   iter_inc;
  logic [ADDR_W-1:0]   load_nxt;

  assign fire     = cfg_out_val & cfg_out_rdy;
  assign last_idx = num_ctx_q - 1'b1;
  assign last_ctx = ({1'b0, ctx_ptr} == last_idx);
  assign iter_inc = iter_count + 1'b1;
  assign load_nxt = (load_ptr == LAST_ADDR) ? '0 : load_ptr + 1'b1;
  assign num_ctx_clamped = ((num_ctx == '0) || (num_ctx > NUM_CTX_MAX)) ? NUM_CTX_MAX : num_ctx;

  assign rf_raddr = ctx_ptr;
  assign cfg_out  = rf_rdata;

  // Loader writes pass straight through so the register file commits them at the next edge.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state == IDLE && cfg_recv_val) begin
      rf_wen   = 1'b1;
      rf_waddr = load_ptr;
      rf_wdata = cfg_recv_msg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      load_ptr     <= '0;
      ctx_ptr      <= '0;
      iter_count   <= '0;
      num_ctx_q    <= NUM_CTX_MAX;
      iter_limit_q <= '0;
      cfg_recv_rdy <= 1'b1;
      cfg_out_val  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_recv_val) load_ptr <= load_nxt;
          if (start) begin
            num_ctx_q    <= num_ctx_clamped;
            iter_limit_q <= iter_limit;
            ctx_ptr      <= '0;
            iter_count   <= '0;
            load_ptr     <= '0;
            state        <= RUN;
            cfg_recv_rdy <= 1'b0;
            cfg_out_val  <= 1'b1;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          if (fire) begin
            if (last_ctx) begin
              ctx_ptr    <= '0;
              iter_count <= iter_inc;
              if (iter_limit_q != '0 && iter_inc == iter_limit_q) begin
                state       <= DONE;
                cfg_out_val <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
              end
            end else begin
              ctx_ptr <= ctx_ptr + 1'b1;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          done         <= 1'b0;
          cfg_recv_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_mem_sequencer.sv
// Directed bench for ctrl_mem_sequencer with a 4-entry register file model.
module tb_ctrl_mem_sequencer;

  localparam int unsigned NUM_CTRL = 4;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned CFG_W    = 49;
  localparam int unsigned ITER_W   = 16;

  logic              clk;
  logic              reset;
  logic [CFG_W-1:0]  cfg_recv_msg;
  logic              cfg_recv_val;
  logic              cfg_recv_rdy;
  logic              start;
  logic [ADDR_W:0]   num_ctx;
  logic [ITER_W-1:0] iter_limit;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [CFG_W-1:0]  rf_wdata;
  logic [ADDR_W-1:0] rf_raddr;
  logic [CFG_W-1:0]  rf_rdata;
  logic [CFG_W-1:0]  cfg_out;
  logic              cfg_out_val;
  logic              cfg_out_rdy;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_count;

  int checks = 0;
  int errors = 0;

  ctrl_mem_sequencer #(
    .NUM_CTRL(NUM_CTRL),
    .ADDR_W  (ADDR_W),
    .CFG_W   (CFG_W),
    .ITER_W  (ITER_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_recv_msg(cfg_recv_msg),
    .cfg_recv_val(cfg_recv_val),
    .cfg_recv_rdy(cfg_recv_rdy),
    .start       (start),
    .num_ctx     (num_ctx),
    .iter_limit  (iter_limit),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .cfg_out     (cfg_out),
    .cfg_out_val (cfg_out_val),
    .cfg_out_rdy (cfg_out_rdy),
    .busy        (busy),
    .done        (done),
    .iter_count  (iter_count)
  );

  // Register file: synchronous write, combinational read, never reset.
  logic [CFG_W-1:0] rf_mem [NUM_CTRL];
  always @(posedge clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input string tag, input logic [ADDR_W-1:0] addr, input logic [CFG_W-1:0] w);
    cfg_recv_val = 1'b1;
    cfg_recv_msg = w;
    #1;
    check({tag, ".wen"},   64'(rf_wen),   64'(1));
    check({tag, ".waddr"}, 64'(rf_waddr), 64'(addr));
    check({tag, ".wdata"}, 64'(rf_wdata), 64'(w));
    tick();
    cfg_recv_val = 1'b0;
    cfg_recv_msg = '0;
  endtask

  task automatic do_start(input logic [ADDR_W:0] nc, input logic [ITER_W-1:0] il);
    start      = 1'b1;
    num_ctx    = nc;
    iter_limit = il;
    tick();
    start = 1'b0;
  endtask

  task automatic run_cycle(input string tag, input logic rdy, input logic [CFG_W-1:0] exp_cfg,
                           input logic [ITER_W-1:0] exp_iter);
    cfg_out_rdy = rdy;
    #1;
    check({tag, ".val"},  64'(cfg_out_val),  64'(1));
    check({tag, ".busy"}, 64'(busy),         64'(1));
    check({tag, ".rdy"},  64'(cfg_recv_rdy), 64'(0));
    check({tag, ".done"}, 64'(done),         64'(0));
    check({tag, ".cfg"},  64'(cfg_out),      64'(exp_cfg));
    check({tag, ".iter"}, 64'(iter_count),   64'(exp_iter));
    tick();
  endtask

  task automatic done_cycle(input string tag, input logic [ITER_W-1:0] exp_iter);
    #1;
    check({tag, ".done"},  64'(done),         64'(1));
    check({tag, ".dval"},  64'(cfg_out_val),  64'(0));
    check({tag, ".dbusy"}, 64'(busy),         64'(0));
    check({tag, ".drdy"},  64'(cfg_recv_rdy), 64'(0));
    check({tag, ".diter"}, 64'(iter_count),   64'(exp_iter));
    tick();
    start = 1'b0;
    #1;
    check({tag, ".idone"}, 64'(done),         64'(0));
    check({tag, ".irdy"},  64'(cfg_recv_rdy), 64'(1));
    check({tag, ".ibusy"}, 64'(busy),         64'(0));
    check({tag, ".iiter"}, 64'(iter_count),   64'(exp_iter));
  endtask

  initial begin
    reset        = 1'b0;
    cfg_recv_msg = '0;
    cfg_recv_val = 1'b0;
    start        = 1'b0;
    num_ctx      = '0;
    iter_limit   = '0;
    cfg_out_rdy  = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst.rdy",   64'(cfg_recv_rdy), 64'(1));
    check("rst.wen",   64'(rf_wen),       64'(0));
    check("rst.waddr", 64'(rf_waddr),     64'(0));
    check("rst.wdata", 64'(rf_wdata),     64'(0));
    check("rst.raddr", 64'(rf_raddr),     64'(0));
    check("rst.val",   64'(cfg_out_val),  64'(0));
    check("rst.busy",  64'(busy),         64'(0));
    check("rst.done",  64'(done),         64'(0));
    check("rst.iter",  64'(iter_count),   64'(0));
    #11 reset = 1'b0;
    tick();

    // Load A..D then run two iterations of four contexts.
    for (int i = 0; i < 4; i++) load_word("t1.load", ADDR_W'(i), CFG_W'(10 + i));
    do_start(3'd4, 16'd2);
    for (int k = 0; k < 8; k++) run_cycle("t1.run", 1'b1, CFG_W'(10 + k % 4), ITER_W'(k / 4));
    done_cycle("t1", 16'd2);

    // Backpressure on ctx 1, with an ignored start in RUN and in DONE.
    do_start(3'd3, 16'd1);
    run_cycle("t2.c0", 1'b1, 49'hA, 16'd0);
    run_cycle("t2.c1h", 1'b0, 49'hB, 16'd0);
    start = 1'b1; num_ctx = 3'd1; iter_limit = 16'd5;
    run_cycle("t2.c1", 1'b1, 49'hB, 16'd0);
    start = 1'b0;
    run_cycle("t2.c2", 1'b1, 49'hC, 16'd0);
    start = 1'b1; num_ctx = 3'd2; iter_limit = 16'd2;
    done_cycle("t2", 16'd1);

    // num_ctx=0 clamps to four contexts; then a single context for three iterations.
    do_start(3'd0, 16'd1);
    for (int k = 0; k < 4; k++) run_cycle("t3.clamp", 1'b1, CFG_W'(10 + k), 16'd0);
    done_cycle("t3a", 16'd1);
    do_start(3'd1, 16'd3);
    for (int k = 0; k < 3; k++) run_cycle("t3.one", 1'b1, 49'hA, ITER_W'(k));
    done_cycle("t3b", 16'd3);

    // Start together with a write: the new word is visible in the first RUN cycle.
    cfg_recv_val = 1'b1; cfg_recv_msg = 49'h1F0;
    start = 1'b1; num_ctx = 3'd1; iter_limit = 16'd1;
    #1;
    check("t4.wen",   64'(rf_wen),   64'(1));
    check("t4.waddr", 64'(rf_waddr), 64'(0));
    tick();
    start = 1'b0; cfg_recv_val = 1'b0;
    run_cycle("t4.run", 1'b1, 49'h1F0, 16'd0);
    done_cycle("t4", 16'd1);
    load_word("t4.reload", 2'd0, 49'hA);

    // Run forever, then asynchronous reset while presenting ctx 2 of the second iteration.
    do_start(3'd4, 16'd0);
    for (int k = 0; k < 6; k++) run_cycle("t5.run", 1'b1, CFG_W'(10 + k % 4), ITER_W'(k / 4));
    cfg_out_rdy = 1'b1;
    #1;
    check("t5.pre.cfg",  64'(cfg_out),    64'hC);
    check("t5.pre.iter", 64'(iter_count), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("t5.rst.busy",  64'(busy),         64'(0));
    check("t5.rst.val",   64'(cfg_out_val),  64'(0));
    check("t5.rst.rdy",   64'(cfg_recv_rdy), 64'(1));
    check("t5.rst.raddr", 64'(rf_raddr),     64'(0));
    check("t5.rst.iter",  64'(iter_count),   64'(0));
    check("t5.rst.done",  64'(done),         64'(0));
    #3 reset = 1'b0;
    tick();
    do_start(3'd4, 16'd1);
    for (int k = 0; k < 4; k++) run_cycle("t5.again", 1'b1, CFG_W'(10 + k), 16'd0);
    done_cycle("t5", 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_mem_sequencer.md
Name: ctrl_mem_sequencer

Overview:
- Control-memory front end for one CGRA tile; sits directly upstream of the 4-entry CGRAConfig_6_4_6_8 register file (1 read port, 1 write port).
- Loads configuration words from the config-loading network into the register file.
- On start, sequences the register-file read address through the active contexts, presenting one configuration per accepted cycle to the tile datapath.
- Counts loop iterations and signals completion.

Parameters:
- NUM_CTRL, 4, number of config entries in the register file.
- ADDR_W, 2, register-file address width, equal to clog2(NUM_CTRL).
- CFG_W, 49, packed CGRAConfig width: ctrl 6 + predicate 1 + fu_in 12 + outport 24 + predicate_in 6.
- ITER_W, 16, iteration counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_recv_msg  in  CFG_W  config word from the loader.
- cfg_recv_val  in  1  loader word valid.
- cfg_recv_rdy  out  1  sequencer accepts a config word.
- start  in  1  single-cycle request to begin execution.
- num_ctx  in  ADDR_W+1  number of active contexts, sampled at start.
- iter_limit  in  ITER_W  iterations to run, sampled at start; 0 means run forever.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  CFG_W  register-file write data.
- rf_raddr  out  ADDR_W  register-file read address.
- rf_rdata  in  CFG_W  register-file read data, combinational from rf_raddr.
- cfg_out  out  CFG_W  current configuration to the tile.
- cfg_out_val  out  1  cfg_out valid.
- cfg_out_rdy  in  1  tile consumes cfg_out this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- iter_count  out  ITER_W  completed iterations.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high; the clock is clk and the reset is reset. All state is reset asynchronously.
- State encoding:
  - FSM states: IDLE, RUN, DONE.
  - Reset values: state=IDLE, load_ptr=0, ctx_ptr=0, iter_count=0, num_ctx_q=NUM_CTRL, iter_limit_q=0.
  - Output reset values: cfg_recv_rdy=1, rf_wen=0, rf_waddr=0, rf_wdata=0, rf_raddr=0, cfg_out_val=0, busy=0, done=0.
  - cfg_out equals rf_rdata at all times; its value is don't-care while cfg_out_val=0.
- IDLE (loading):
  - cfg_recv_rdy=1.
  - When cfg_recv_val=1, in the same cycle: rf_wen=1, rf_waddr=load_ptr, rf_wdata=cfg_recv_msg. load_ptr increments and wraps from NUM_CTRL-1 to 0.
  - The write is combinational pass-through; the register file commits it at the next edge.
- Start (IDLE with start=1):
  - Capture num_ctx into num_ctx_q. Values of 0 or greater than NUM_CTRL clamp to NUM_CTRL.
  - Capture iter_limit into iter_limit_q.
  - Clear ctx_ptr, iter_count and load_ptr. Next state is RUN.
  - start together with cfg_recv_val: the write is performed, and RUN begins next cycle with that word visible.
  - start outside IDLE is ignored.
- RUN:
  - cfg_recv_rdy=0, rf_wen=0, busy=1.
  - rf_raddr=ctx_ptr; cfg_out_val=1.
  - The first configuration (ctx 0) is valid in the first cycle after start.
  - Handshake fire = cfg_out_val & cfg_out_rdy. Without fire, ctx_ptr holds and cfg_out is stable.
  - On fire with ctx_ptr < num_ctx_q-1: ctx_ptr increments.
  - On fire with ctx_ptr = num_ctx_q-1 (iteration end):
    - ctx_ptr goes to 0 and iter_count increments; iter_count wraps mod 2^ITER_W.
    - If iter_limit_q != 0 and iter_count+1 == iter_limit_q, next state is DONE.
- DONE:
  - Lasts one cycle: done=1, cfg_out_val=0, busy=0, cfg_recv_rdy=0.
  - Next state is IDLE. iter_count holds its final value until the next start.
- Reset mid-RUN: immediate return to IDLE with reset values. Register-file contents are not cleared and remain valid for a restart.
- num_ctx_q=1: every fire ends an iteration.
- iter_limit=0: RUN continues until reset; iter_count wraps silently.

Test Plan:
- Load then run: load words 0xA, 0xB, 0xC, 0xD (zero-extended) with cfg_recv_val=1 for 4 cycles, then start with num_ctx=4, iter_limit=2, cfg_out_rdy=1 -> rf_waddr 0,1,2,3; cfg_out A,B,C,D,A,B,C,D on consecutive cycles; iter_count reaches 2; done pulses one cycle after the last D; then back to IDLE.
- Backpressure: num_ctx=3, iter_limit=1, cfg_out_rdy low in cycle 2 of RUN -> ctx 1 held for 2 cycles with cfg_out stable; sequence A,B,B,C; done after C.
- Clamp and single context: num_ctx=0, iter_limit=1 -> 4 contexts run. Then num_ctx=1, iter_limit=3 -> cfg_out=A for 3 fires, iter_count=3, done.
- Simultaneous start and write: in IDLE with load_ptr=0, cfg_recv_val=1 with msg 0x1F0 and start=1, num_ctx=1, iter_limit=1 -> first RUN cycle cfg_out=0x1F0.
- Reset mid-run: iter_limit=0, assert reset asynchronously in RUN at ctx 2 -> outputs drop to reset values without waiting for a clock edge. After release, start with num_ctx=4 -> cfg_out A,B,C,D (old contents retained); cfg_recv_rdy=0 throughout RUN.
- Ignored start: pulse start during RUN and during DONE -> no change to ctx_ptr, iter_count or captured limits.
